// File: rtl/ifu_axi_rd_master.sv
// ifu_axi_rd_master: instruction-fetch AXI-lite read master.
// Takes one fetch PC at a time, issues a single AR beat, captures the R beat
// and hands the instruction to decode over a valid/ready handshake.
// A flush discards whatever fetch or result is in flight. Write channels idle.
// Optional build macro IFU_RESP_CHECK_EN adds inst_err and replaces
// error-response data with NOP_INST.
module ifu_axi_rd_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_pc,
  input  logic                flush,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [DATA_W-1:0]   inst,
  output logic [ADDR_W-1:0]   inst_pc,
`ifdef IFU_RESP_CHECK_EN
  output logic                inst_err,
`endif
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state;
  logic                drop;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   r_inst;
  logic                r_fire;

  // This master only reads; the write channels stay permanently idle.
  assign awaddr  = '0;
  assign awvalid = 1'b0;
  assign wdata   = '0;
  assign wstrb   = '0;
  assign wvalid  = 1'b0;
  assign bready  = 1'b0;

  assign req_ready = (state == IDLE);

  // An R beat is taken in RESP, or in ADDR when a combinational slave
  // answers in the same cycle as the AR handshake.
  assign r_fire = rvalid && ((state == RESP) || ((state == ADDR) && arready));

`ifdef IFU_RESP_CHECK_EN
  logic r_err;
  assign r_err  = |rresp;
  assign r_inst = r_err ? NOP_INST : rdata;
  logic unused_inputs;
  assign unused_inputs = ^{awready, wready, bresp, bvalid};
`else
  assign r_inst = rdata;
  logic unused_inputs;
  assign unused_inputs = ^{awready, wready, bresp, bvalid, rresp};
`endif

  // Fetch FSM with all bus and decode-side outputs registered alongside state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      drop       <= 1'b0;
      pc_q       <= '0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= NOP_INST;
      inst_pc    <= '0;
`ifdef IFU_RESP_CHECK_EN
      inst_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            pc_q    <= req_pc;
            araddr  <= req_pc;
            arvalid <= 1'b1;
            rready  <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR, RESP: begin
          if ((state == ADDR) && arready) begin
            arvalid <= 1'b0;
          end
          if (r_fire) begin
            rready <= 1'b0;
            drop   <= 1'b0;
            if (drop || flush) begin
              state <= IDLE;
            end else begin
              inst       <= r_inst;
              inst_pc    <= pc_q;
              inst_valid <= 1'b1;
`ifdef IFU_RESP_CHECK_EN
              inst_err   <= r_err;
`endif
              state      <= HOLD;
            end
          end else begin
            if (flush) begin
              drop <= 1'b1;
            end
            if ((state == ADDR) && arready) begin
              state <= RESP;
            end
          end
        end
        HOLD: begin
          if (inst_ready || flush) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
`ifdef IFU_RESP_CHECK_EN
            inst_err   <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_axi_rd_master.sv
// tb_ifu_axi_rd_master: directed bench for ifu_axi_rd_master.
// Expected instructions are queued when the slave side drives an R beat and
// compared when decode sees inst_valid. Build with IFU_RESP_CHECK_EN to
// also exercise the error-response path.
module tb_ifu_axi_rd_master;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFU_RESP_CHECK_EN
  logic        inst_err;
`endif
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];
  logic [31:0] held_inst;

  ifu_axi_rd_master #(.ADDR_W(32), .DATA_W(32), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
`ifdef IFU_RESP_CHECK_EN
    .inst_err(inst_err),
`endif
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Free-running clock; inputs change and outputs are sampled on negedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one request in IDLE; returns on the negedge after the handshake.
  task automatic applyStimulus(input logic [31:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    checkOutput("req_ready_idle", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_inst(input string tag);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (inst_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_valid"}, inst_valid, 1'b1);
    checkOutput({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({tag, "_inst"}, inst, e.inst);
      checkOutput({tag, "_pc"}, inst_pc, e.pc);
    end
  endtask

  task automatic accept_inst(input string tag);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, inst_valid, 1'b0);
    checkOutput({tag, "_nop"}, inst, NOP);
    checkOutput({tag, "_req_ready"}, req_ready, 1'b1);
  endtask

  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp);
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    @(negedge clk);
    rvalid = 1'b0;
    rresp  = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0; inst_ready = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_arvalid", arvalid, 1'b0);
    checkOutput("rst_araddr", araddr, 32'h0);
    checkOutput("rst_rready", rready, 1'b0);
    checkOutput("rst_inst_valid", inst_valid, 1'b0);
    checkOutput("rst_inst", inst, NOP);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_req_ready", req_ready, 1'b1);
    checkOutput("wr_idle", {awvalid, wvalid, bready, awaddr, wdata, wstrb}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Request coinciding with flush is ignored
    req_valid = 1'b1; req_pc = 32'h1234_5678; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_req_arvalid", arvalid, 1'b0);
    checkOutput("flush_req_ready", req_ready, 1'b1);

    // Zero-wait slave, R beat the cycle after AR
    arready = 1'b1;
    applyStimulus(32'h8000_0000);
    checkOutput("zw_arvalid", arvalid, 1'b1);
    checkOutput("zw_araddr", araddr, 32'h8000_0000);
    checkOutput("zw_req_busy", req_ready, 1'b0);
    @(negedge clk);
    arready = 1'b0;
    checkOutput("zw_resp_arvalid", arvalid, 1'b0);
    checkOutput("zw_resp_rready", rready, 1'b1);
    exp_q.push_back('{inst: 32'h0000_0297, pc: 32'h8000_0000});
    r_beat(32'h0000_0297, 2'b00);
    wait_inst("zw");
    checkOutput("zw_hold_rready", rready, 1'b0);
    accept_inst("zw");

    // Combinational slave: arready and rvalid together
    applyStimulus(32'h8000_0004);
    arready = 1'b1;
    exp_q.push_back('{inst: 32'h00a0_0513, pc: 32'h8000_0004});
    r_beat(32'h00a0_0513, 2'b00);
    arready = 1'b0;
    checkOutput("comb_arvalid", arvalid, 1'b0);
    wait_inst("comb");
    accept_inst("comb");

    // arready held low for three cycles
    applyStimulus(32'h8000_0100);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("arwait_arvalid_%0d", i), arvalid, 1'b1);
      checkOutput($sformatf("arwait_araddr_%0d", i), araddr, 32'h8000_0100);
      @(negedge clk);
    end
    arready = 1'b1;
    checkOutput("arwait_arvalid_4", arvalid, 1'b1);
    @(negedge clk);
    arready = 1'b0;
    checkOutput("arwait_done", arvalid, 1'b0);
    exp_q.push_back('{inst: 32'hfe01_0113, pc: 32'h8000_0100});
    r_beat(32'hfe01_0113, 2'b00);
    wait_inst("arwait");

    // Decode stalls five cycles in HOLD
    held_inst = inst;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_inst_%0d", i), inst, 32'hfe01_0113);
      checkOutput($sformatf("stall_valid_%0d", i), inst_valid, 1'b1);
      checkOutput($sformatf("stall_req_ready_%0d", i), req_ready, 1'b0);
      @(negedge clk);
    end
    checkOutput("stall_stable", inst, held_inst);
    accept_inst("stall");

    // Flush during ADDR while arready is low
    applyStimulus(32'h8000_0200);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("fladdr_arvalid_held", arvalid, 1'b1);
    checkOutput("fladdr_araddr", araddr, 32'h8000_0200);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    checkOutput("fladdr_rready", rready, 1'b1);
    r_beat(32'hDEAD_BEEF, 2'b00);
    checkOutput("fladdr_rready_done", rready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("fladdr_no_inst_%0d", i), inst_valid, 1'b0);
      @(negedge clk);
    end
    checkOutput("fladdr_idle", req_ready, 1'b1);

    // Flush while waiting in RESP
    arready = 1'b1;
    applyStimulus(32'h8000_0300);
    @(negedge clk);
    arready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    r_beat(32'h1111_1111, 2'b00);
    checkOutput("flresp_no_inst", inst_valid, 1'b0);
    checkOutput("flresp_idle", req_ready, 1'b1);

    // Flush while holding an instruction
    arready = 1'b1;
    applyStimulus(32'h8000_0400);
    @(negedge clk);
    arready = 1'b0;
    exp_q.push_back('{inst: 32'h0010_0093, pc: 32'h8000_0400});
    r_beat(32'h0010_0093, 2'b00);
    wait_inst("flhold");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flhold_valid", inst_valid, 1'b0);
    checkOutput("flhold_nop", inst, NOP);
    checkOutput("flhold_idle", req_ready, 1'b1);

    // Reset asserted in RESP abandons the transaction
    arready = 1'b1;
    applyStimulus(32'h8000_0500);
    @(negedge clk);
    arready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstresp_arvalid", arvalid, 1'b0);
    checkOutput("rstresp_rready", rready, 1'b0);
    checkOutput("rstresp_inst_valid", inst_valid, 1'b0);
    checkOutput("rstresp_inst", inst, NOP);
    rst_n = 1'b1;
    r_beat(32'h2222_2222, 2'b00);
    checkOutput("rstresp_stray_r", inst_valid, 1'b0);

`ifdef IFU_RESP_CHECK_EN
    // Error response yields NOP with inst_err
    arready = 1'b1;
    applyStimulus(32'h8000_0600);
    @(negedge clk);
    arready = 1'b0;
    exp_q.push_back('{inst: NOP, pc: 32'h8000_0600});
    r_beat(32'h3333_3333, 2'b10);
    wait_inst("err");
    checkOutput("err_flag", inst_err, 1'b1);
    accept_inst("err");
    checkOutput("err_flag_clear", inst_err, 1'b0);
`endif

    // Recovery after all of the above
    arready = 1'b1;
    applyStimulus(32'h8000_0700);
    @(negedge clk);
    arready = 1'b0;
    exp_q.push_back('{inst: 32'h0000_006f, pc: 32'h8000_0700});
    r_beat(32'h0000_006f, 2'b00);
    wait_inst("final");
    accept_inst("final");
    checkOutput("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ifu_axi_rd_master.md
Name: ifu_axi_rd_master

Overview:
- Instruction-fetch-side AXI-lite read master.
- Accepts one fetch request (PC) from upstream PC logic and issues a single AR beat on the AXI-lite bus.
- Captures the R beat and presents the instruction to the decode stage over a valid/ready handshake.
- Supports a flush that discards in-flight results. One outstanding transaction max; write channels are driven idle.

Parameters:
- ADDR_W, 32, AXI/PC address width
- DATA_W, 32, AXI data / instruction width
- NOP_INST, 32'h0000_0013, value driven on inst when no valid instruction is held

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  fetch request valid
- req_ready  out  1  master can accept request
- req_pc  in  ADDR_W  fetch address
- flush  in  1  discard current fetch/result
- inst_valid  out  1  instruction valid to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  DATA_W  fetched instruction
- inst_pc  out  ADDR_W  PC of inst
- araddr  out  ADDR_W  AR address
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_W  R data
- rresp  in  2  R response
- rvalid  in  1  R valid
- rready  out  1  R ready
- awaddr  out  ADDR_W  tied 0
- awvalid  out  1  tied 0
- awready  in  1  ignored
- wdata  out  DATA_W  tied 0
- wstrb  out  DATA_W/8  tied 0
- wvalid  out  1  tied 0
- wready  in  1  ignored
- bresp  in  2  ignored
- bvalid  in  1  ignored
- bready  out  1  tied 0

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, drop=0, arvalid=0, araddr=0, rready=0, inst_valid=0, inst=NOP_INST, inst_pc=0.
  - All outputs are registered or decoded from state, so they hold these values while in reset.
  - Reset mid-transaction abandons it; no response is tracked afterward.
- FSM states:
  - IDLE: req_ready=1. On req_valid & !flush: latch req_pc into pc_q, drive araddr=req_pc, go ADDR. A request that coincides with flush is ignored.
  - ADDR: arvalid=1, rready=1, araddr stable.
    - arvalid must never drop before arready, even on flush. Flush sets drop=1.
    - On arready: if rvalid is also high the same cycle (combinational slave), take the R beat per R rules; otherwise go RESP.
  - RESP: rready=1, arvalid=0. On rvalid: if drop|flush, go IDLE and clear drop; else inst<=rdata, inst_pc<=pc_q, go HOLD.
  - HOLD: inst_valid=1; inst and inst_pc stable until inst_ready. On inst_ready or flush: go IDLE, inst_valid=0 next cycle, inst<=NOP_INST.
- req_ready=1 only in IDLE. No pipelining of requests.
- Latency with a zero-wait slave: req handshake in cycle 0; arvalid in cycle 1; arready+rvalid in cycle 1 or rvalid in cycle 2; inst_valid in the cycle after the R handshake.
- Flush is effective in every state. No instruction from a pre-flush request ever reaches inst_valid=1.
- rresp is ignored unless the optional feature is enabled.

Optional Feature:
- IFU_RESP_CHECK_EN defined:
  - Adds port inst_err (out, 1, reset 0).
  - A non-zero rresp loads inst=NOP_INST and inst_err=1 instead of rdata. inst_err is valid with inst_valid and clears on leaving HOLD.
- Undefined: no inst_err port; rdata is always used.

Test Plan:
- Zero-wait slave (arready=1, rvalid the cycle after AR), req_pc=0x8000_0000, mem=0x0000_0297 -> araddr=0x8000_0000, inst=0x0000_0297, inst_pc=0x8000_0000, inst_valid=1.
- arready held low 3 cycles -> arvalid stays 1 and araddr stable all 3 cycles; the handshake completes on cycle 4.
- inst_ready low 5 cycles in HOLD -> inst stable and req_ready=0 throughout; after the handshake req_ready=1 next cycle.
- flush during ADDR, then rvalid with 0xDEADBEEF -> arvalid held until arready; R beat consumed; inst_valid never 1; state back in IDLE.
- Reset asserted in RESP -> next cycle arvalid=0, rready=0, inst_valid=0, inst=0x0000_0013.
- IFU_RESP_CHECK_EN, rresp=2'b10 -> inst_valid=1, inst_err=1, inst=0x0000_0013.
